// File: rtl/mips_boot_pkg.sv
// Shared types and constants for the MIPS boot/run controller.
package mips_boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_CLR,
        ST_RUN,
        ST_DONE
    } boot_state_t;

    localparam logic        MEM_IMEM       = 1'b0;
    localparam logic        MEM_DMEM       = 1'b1;
    localparam int unsigned BYTES_PER_WORD = 4;

    // Byte k of a big-endian word: k = 0 is the most significant byte.
    function automatic logic [7:0] be_byte(input logic [31:0] word, input logic [1:0] k);
        return word[8*(3-k) +: 8];
    endfunction

endpackage

// File: rtl/mips_word_serialiser.sv
// Serialises one latched 32-bit word into four consecutive big-endian byte writes.
module mips_word_serialiser
    import mips_boot_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_sel,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_data,
    output logic              o_we,
    output logic              o_sel,
    output logic [ADDR_W-1:0] o_addr,
    output logic [7:0]        o_byte,
    output logic              o_done
);

    logic              r_active;
    logic [1:0]        r_idx;
    logic              r_sel;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_data;
    logic              w_last;

    assign w_last = (r_idx == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_idx    <= '0;
            r_sel    <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_idx    <= '0;
            r_sel    <= i_sel;
            r_addr   <= i_addr;
            r_data   <= i_data;
        end else if (r_active) begin
            r_idx <= r_idx + 2'd1;
            if (w_last) begin
                r_active <= 1'b0;
            end
        end
    end

    // Outputs are forced to zero between words so idle bus values match reset.
    always_comb begin
        o_we   = 1'b0;
        o_sel  = 1'b0;
        o_addr = '0;
        o_byte = '0;
        o_done = 1'b0;
        if (r_active) begin
            o_we   = 1'b1;
            o_sel  = r_sel;
            o_addr = r_addr + ADDR_W'(r_idx);
            o_byte = be_byte(r_data, r_idx);
            o_done = w_last;
        end
    end

endmodule

// File: rtl/mips_boot_ctrl.sv
// Boot/run controller: loads IMEM/DMEM byte-wise, clears the register file,
// releases the core and stops it on halt (PC stuck) or cycle-budget timeout.
module mips_boot_ctrl
    import mips_boot_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned IMEM_BYTES  = 256,
    parameter int unsigned DMEM_BYTES  = 256,
    parameter int unsigned RUN_CYCLES  = 20,
    parameter int unsigned HALT_REPEAT = 3,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic              ld_sel,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    output logic              mem_we,
    output logic              mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wbyte,
    output logic              rf_clr,
    output logic              cpu_rst_n,
    input  logic [31:0]       pc_in,
    output logic              busy,
    output logic              done,
    output logic              halted,
    output logic              timeout,
    output logic              ld_err,
    output logic [CNT_W-1:0]  cycle_cnt
);

    localparam int unsigned REP_W = $clog2(HALT_REPEAT + 1);

    boot_state_t       r_state;
    boot_state_t       w_next;
    logic              r_last;
    logic              r_ld_err;
    logic              r_halted;
    logic              r_timeout;
    logic [CNT_W-1:0]  r_cnt;
    logic [REP_W-1:0]  r_rep;
    logic [31:0]       r_prev_pc;

    logic              w_hs;
    logic              w_bad;
    logic              w_start;
    logic [ADDR_W-1:0] w_limit;
    logic [REP_W-1:0]  w_rep_nxt;
    logic              w_halt;
    logic              w_tmo;
    logic              w_ser_done;

    assign w_hs      = ld_valid & ld_ready;
    assign w_limit   = (ld_sel == MEM_DMEM) ? ADDR_W'(DMEM_BYTES - BYTES_PER_WORD)
                                            : ADDR_W'(IMEM_BYTES - BYTES_PER_WORD);
    assign w_bad     = (ld_addr[1:0] != 2'b00) | (ld_addr > w_limit);
    assign w_start   = w_hs & ~w_bad;
    assign w_rep_nxt = (pc_in == r_prev_pc) ? r_rep + REP_W'(1) : '0;
    // Halt takes priority when it coincides with the last budgeted cycle.
    assign w_halt    = (r_state == ST_RUN) && (w_rep_nxt == REP_W'(HALT_REPEAT - 1));
    assign w_tmo     = (r_state == ST_RUN) && !w_halt && (r_cnt == CNT_W'(RUN_CYCLES - 1));

    mips_word_serialiser #(
        .ADDR_W (ADDR_W)
    ) u_ser (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_start),
        .i_sel   (ld_sel),
        .i_addr  (ld_addr),
        .i_data  (ld_data),
        .o_we    (mem_we),
        .o_sel   (mem_sel),
        .o_addr  (mem_addr),
        .o_byte  (mem_wbyte),
        .o_done  (w_ser_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_hs) begin
                    if (w_bad) begin
                        w_next = ld_last ? ST_CLR : ST_IDLE;
                    end else begin
                        w_next = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (w_ser_done) begin
                    w_next = r_last ? ST_CLR : ST_IDLE;
                end
            end
            ST_CLR:  w_next = ST_RUN;
            ST_RUN: begin
                if (w_halt || w_tmo) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: w_next = ST_DONE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ld_ready  = 1'b0;
        rf_clr    = 1'b0;
        cpu_rst_n = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            ST_IDLE:  ld_ready = 1'b1;
            ST_WRITE: busy = 1'b1;
            ST_CLR: begin
                busy   = 1'b1;
                rf_clr = 1'b1;
            end
            ST_RUN: begin
                busy      = 1'b1;
                cpu_rst_n = 1'b1;
            end
            ST_DONE:  done = 1'b1;
            default:  ld_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last    <= 1'b0;
            r_ld_err  <= 1'b0;
            r_halted  <= 1'b0;
            r_timeout <= 1'b0;
            r_cnt     <= '0;
            r_rep     <= '0;
            r_prev_pc <= '0;
        end else begin
            r_prev_pc <= pc_in;
            if (w_start) begin
                r_last <= ld_last;
            end
            if (w_hs && w_bad) begin
                r_ld_err <= 1'b1;
            end
            if (r_state == ST_RUN) begin
                r_rep <= w_rep_nxt;
                if (r_cnt != '1) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                if (w_halt) begin
                    r_halted <= 1'b1;
                end
                if (w_tmo) begin
                    r_timeout <= 1'b1;
                end
            end else begin
                r_rep <= '0;
            end
        end
    end

    assign halted    = r_halted;
    assign timeout   = r_timeout;
    assign ld_err    = r_ld_err;
    assign cycle_cnt = r_cnt;

endmodule

// File: tb/tb_mips_boot_ctrl.sv
// Self-checking bench for mips_boot_ctrl: directed load/run scenarios plus
// randomized loads and PC traces checked against a behavioural model.
module tb_mips_boot_ctrl;

    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned IMEM_BYTES  = 256;
    localparam int unsigned DMEM_BYTES  = 256;
    localparam int unsigned RUN_CYCLES  = 20;
    localparam int unsigned HALT_REPEAT = 3;
    localparam int unsigned CNT_W       = 16;

    logic              clk;
    logic              rst_n;
    logic              ld_valid;
    logic              ld_ready;
    logic              ld_sel;
    logic [ADDR_W-1:0] ld_addr;
    logic [31:0]       ld_data;
    logic              ld_last;
    logic              mem_we;
    logic              mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wbyte;
    logic              rf_clr;
    logic              cpu_rst_n;
    logic [31:0]       pc_in;
    logic              busy;
    logic              done;
    logic              halted;
    logic              timeout;
    logic              ld_err;
    logic [CNT_W-1:0]  cycle_cnt;

    mips_boot_ctrl #(
        .ADDR_W      (ADDR_W),
        .IMEM_BYTES  (IMEM_BYTES),
        .DMEM_BYTES  (DMEM_BYTES),
        .RUN_CYCLES  (RUN_CYCLES),
        .HALT_REPEAT (HALT_REPEAT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_sel    (ld_sel),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .mem_we    (mem_we),
        .mem_sel   (mem_sel),
        .mem_addr  (mem_addr),
        .mem_wbyte (mem_wbyte),
        .rf_clr    (rf_clr),
        .cpu_rst_n (cpu_rst_n),
        .pc_in     (pc_in),
        .busy      (busy),
        .done      (done),
        .halted    (halted),
        .timeout   (timeout),
        .ld_err    (ld_err),
        .cycle_cnt (cycle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks;
    int unsigned n_err;

    // Memory image as actually written by the DUT.
    logic [7:0]  cap_mem [2][256];
    int unsigned n_we;
    int unsigned n_oob;

    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            n_we <= n_we + 1;
            if (mem_addr < 256) cap_mem[mem_sel][mem_addr[7:0]] <= mem_wbyte;
            else                n_oob <= n_oob + 1;
        end
    end

    // Reference model state.
    logic [7:0]  exp_mem [2][256];
    bit          exp_wr  [2][256];
    int unsigned exp_we;
    bit          exp_err;
    logic [31:0] seq [64];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        ld_sel   = 1'b0;
        ld_addr  = '0;
        ld_data  = '0;
        pc_in    = 32'hFFFF_FFF0;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        exp_err  = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge right after the handshake edge.
    task automatic send_word(input logic sel, input logic [31:0] addr,
                             input logic [31:0] data, input logic last);
        int unsigned t = 0;
        int unsigned size;
        bit ok;
        while (ld_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("ld_ready_wait", ld_ready, 1);
        ld_valid = 1'b1;
        ld_sel   = sel;
        ld_addr  = addr;
        ld_data  = data;
        ld_last  = last;
        @(negedge clk);
        ld_valid = 1'b0;
        ld_sel   = 1'($urandom);
        ld_addr  = $urandom;
        ld_data  = $urandom;
        ld_last  = 1'($urandom);
        size = sel ? DMEM_BYTES : IMEM_BYTES;
        ok   = (addr % 4 == 0) && (addr + 4 <= size);
        if (ok) begin
            for (int j = 0; j < 4; j++) begin
                exp_mem[sel][addr + j] = 8'((data >> (24 - 8 * j)) & 32'hFF);
                exp_wr[sel][addr + j]  = 1'b1;
            end
            exp_we += 4;
            chk("wr_start_we", mem_we, 1);
            chk("wr_start_busy", busy, 1);
        end else begin
            exp_err = 1'b1;
            chk("bad_no_we", mem_we, 0);
            chk("bad_err", ld_err, 1);
        end
    endtask

    task automatic wait_clr();
        int unsigned t = 0;
        while (rf_clr !== 1'b1 && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("clr_seen", rf_clr, 1);
        chk("clr_core_held", cpu_rst_n, 0);
    endtask

    // Expected run outcome: halt at the first RUN cycle that closes a window of
    // HALT_REPEAT identical PC samples (seq[0] is the sample before RUN).
    function automatic void model_run(output logic h, output logic t, output int unsigned cnt);
        bit eq;
        h = 1'b0;
        t = 1'b0;
        cnt = RUN_CYCLES;
        for (int i = 0; i < int'(RUN_CYCLES); i++) begin
            if (i + 2 >= int'(HALT_REPEAT)) begin
                eq = 1'b1;
                for (int j = i + 2 - int'(HALT_REPEAT); j <= i; j++)
                    if (seq[j] != seq[j + 1]) eq = 1'b0;
                if (eq) begin
                    h = 1'b1;
                    cnt = i + 1;
                    return;
                end
            end
        end
        t = 1'b1;
    endfunction

    // Called at the negedge of the CLR cycle.
    task automatic run_check(input string tag, input logic eh, input logic et,
                             input int unsigned ecnt);
        bit seen = 1'b0;
        pc_in = seq[0];
        for (int k = 1; k < int'(RUN_CYCLES) + 4; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            pc_in = seq[k];
            if (k == 1) begin
                chk({tag, "_released"}, cpu_rst_n, 1);
                chk({tag, "_clr_pulse_end"}, rf_clr, 0);
            end
        end
        chk({tag, "_done"}, seen, 1);
        chk({tag, "_halted"}, halted, eh);
        chk({tag, "_timeout"}, timeout, et);
        chk({tag, "_cycle_cnt"}, cycle_cnt, ecnt);
        chk({tag, "_core_held"}, cpu_rst_n, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ready"}, ld_ready, 0);
        @(negedge clk);
        chk({tag, "_hold_cnt"}, cycle_cnt, ecnt);
        chk({tag, "_hold_done"}, done, 1);
    endtask

    logic [7:0] b_tbl [4];
    logic       mh, mt;
    int unsigned mc;

    initial begin
        exp_we  = 0;
        exp_err = 1'b0;

        // Reset values
        do_reset();
        chk("rst_ld_ready", ld_ready, 1);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_sel", mem_sel, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wbyte", mem_wbyte, 0);
        chk("rst_rf_clr", rf_clr, 0);
        chk("rst_cpu_rst_n", cpu_rst_n, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_halted", halted, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_ld_err", ld_err, 0);
        chk("rst_cycle_cnt", cycle_cnt, 0);

        // IMEM word, big-endian byte order
        b_tbl = '{8'h8C, 8'h01, 8'h00, 8'h00};
        send_word(1'b0, 32'h0, 32'h8C01_0000, 1'b0);
        for (int j = 0; j < 4; j++) begin
            chk("imem_we", mem_we, 1);
            chk("imem_sel", mem_sel, 0);
            chk("imem_addr", mem_addr, j);
            chk("imem_byte", mem_wbyte, b_tbl[j]);
            chk("imem_not_ready", ld_ready, 0);
            @(negedge clk);
        end
        chk("imem_after_we", mem_we, 0);
        chk("imem_after_ready", ld_ready, 1);

        // DMEM word with last, then CLR and timeout run
        b_tbl = '{8'h00, 8'h00, 8'h00, 8'h03};
        send_word(1'b1, 32'h4, 32'h0000_0003, 1'b1);
        for (int j = 0; j < 4; j++) begin
            chk("dmem_sel", mem_sel, 1);
            chk("dmem_addr", mem_addr, 4 + j);
            chk("dmem_byte", mem_wbyte, b_tbl[j]);
            chk("dmem_no_clr", rf_clr, 0);
            @(negedge clk);
        end
        chk("dmem_clr", rf_clr, 1);
        chk("dmem_clr_held", cpu_rst_n, 0);
        seq[0] = 32'hFFFF_FFF0;
        for (int k = 1; k < 64; k++) seq[k] = 32'(4 * (k - 1));
        model_run(mh, mt, mc);
        chk("model_tmo_sanity", {mh, mt, 8'(mc)}, {1'b0, 1'b1, 8'd20});
        run_check("tmo", 1'b0, 1'b1, 20);

        // Halt: PC stuck at 0x24 from RUN cycle 5
        do_reset();
        send_word(1'b0, 32'h10, 32'h2001_0005, 1'b1);
        wait_clr();
        seq[0] = 32'hFFFF_FFF0;
        for (int k = 1; k < 64; k++) seq[k] = (k - 1 < 5) ? 32'(4 * (k - 1)) : 32'h24;
        run_check("halt", 1'b1, 1'b0, 8);

        // Misaligned last word goes straight to CLR; halt coincides with timeout
        do_reset();
        send_word(1'b0, 32'h2, 32'hDEAD_BEEF, 1'b1);
        wait_clr();
        chk("bad_last_err", ld_err, 1);
        seq[0] = 32'hFFFF_FFF0;
        for (int k = 1; k < 64; k++) seq[k] = (k - 1 < 17) ? 32'(4 * (k - 1)) : 32'h100;
        run_check("coincide", 1'b1, 1'b0, 20);

        // Randomized loads and PC traces
        for (int r = 0; r < 8; r++) begin
            int unsigned nw;
            int unsigned rng;
            logic [31:0] a;
            do_reset();
            chk("rnd_rst_err", ld_err, 0);
            nw = $urandom_range(1, 5);
            for (int w = 0; w < int'(nw); w++) begin
                if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 300);
                else                           a = 4 * $urandom_range(0, 63);
                send_word(1'($urandom), a, $urandom, (w == int'(nw) - 1));
            end
            wait_clr();
            chk("rnd_ld_err", ld_err, exp_err);
            rng = $urandom_range(1, 6);
            for (int k = 0; k < 64; k++) seq[k] = 4 * $urandom_range(0, rng - 1);
            model_run(mh, mt, mc);
            run_check("rnd", mh, mt, mc);
        end

        // Address boundaries: last legal word, misaligned, one past the end
        do_reset();
        send_word(1'b0, IMEM_BYTES - 4, 32'hA1B2_C3D4, 1'b0);
        send_word(1'b1, DMEM_BYTES - 4, 32'h5566_7788, 1'b0);
        send_word(1'b0, 32'h2, 32'h1111_1111, 1'b0);
        repeat (2) @(negedge clk);
        chk("mis_ready", ld_ready, 1);
        send_word(1'b0, IMEM_BYTES, 32'h2222_2222, 1'b0);
        send_word(1'b1, DMEM_BYTES - 2, 32'h3333_3333, 1'b0);
        repeat (3) @(negedge clk);
        chk("oor_err_sticky", ld_err, 1);
        chk("oor_idle", ld_ready, 1);
        chk("oor_no_we", mem_we, 0);

        // Memory image against the model
        chk("we_count", n_we, exp_we);
        chk("oob_writes", n_oob, 0);
        for (int s = 0; s < 2; s++)
            for (int a2 = 0; a2 < 256; a2++)
                if (exp_wr[s][a2]) chk($sformatf("mem%0d_%0h", s, a2), cap_mem[s][a2], exp_mem[s][a2]);

        // Asynchronous reset in the middle of WRITE
        send_word(1'b0, 32'h40, 32'hCAFE_F00D, 1'b0);
        @(negedge clk);
        chk("abort_pre_we", mem_we, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_we", mem_we, 0);
        chk("abort_ready", ld_ready, 1);
        chk("abort_err", ld_err, 0);
        chk("abort_busy", busy, 0);
        chk("abort_addr", mem_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_idle_we", mem_we, 0);
        chk("abort_idle_ready", ld_ready, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mips_boot_ctrl.md
Name: mips_boot_ctrl

Overview:
Hardware boot/run controller for the single-cycle MIPS core. It accepts a stream of 32-bit words tagged for instruction or data memory and serialises each word into big-endian byte writes on the byte-addressed IM/DM arrays. It holds the core in reset during loading, pulses a register-file clear, then releases the core. It stops the run on a halt (PC stuck) or on a cycle-budget timeout.

Parameters:
ADDR_W, 32, byte-address width of both memories
IMEM_BYTES, 256, instruction memory size in bytes; legal address range is 0..IMEM_BYTES-4
DMEM_BYTES, 256, data memory size in bytes; legal address range is 0..DMEM_BYTES-4
RUN_CYCLES, 20, maximum core cycles after release before timeout
HALT_REPEAT, 3, consecutive cycles with unchanged PC that declare a halt (HALT_REPEAT >= 2)
CNT_W, 16, width of the cycle counter

Ports:
clk  in  1  clock (all logic on posedge)
rst_n  in  1  asynchronous active-low reset
ld_valid  in  1  load word valid
ld_ready  out  1  controller can accept a word
ld_sel  in  1  target memory: 0 = IMEM, 1 = DMEM
ld_addr  in  ADDR_W  byte address of the word; must be word-aligned
ld_data  in  32  word to store, big-endian
ld_last  in  1  this word is the final load word
mem_we  out  1  byte write strobe
mem_sel  out  1  target of the current byte write (0 = IMEM, 1 = DMEM)
mem_addr  out  ADDR_W  byte address of the current byte write
mem_wbyte  out  8  byte data of the current byte write
rf_clr  out  1  one-cycle register-file clear pulse
cpu_rst_n  out  1  core reset; low = core held
pc_in  in  32  core PC
busy  out  1  loading or running
done  out  1  run finished (sticky until reset)
halted  out  1  run ended by halt detection
timeout  out  1  run ended by RUN_CYCLES exhaustion
ld_err  out  1  sticky: at least one word was misaligned or out of range
cycle_cnt  out  CNT_W  core cycles elapsed in RUN; saturates

Behaviour:
- Reset (async, rst_n = 0) forces these values: state = IDLE, ld_ready = 1, mem_we = 0, mem_sel = 0, mem_addr = 0, mem_wbyte = 0, rf_clr = 0, cpu_rst_n = 0, busy = 0, done = 0, halted = 0, timeout = 0, ld_err = 0, cycle_cnt = 0, internal byte index = 0.
- Reset asserted mid-WRITE or mid-RUN aborts immediately. Bytes already written stay in memory; no rollback.
- States: IDLE, WRITE, CLR, RUN, DONE.
- IDLE:
  - ld_ready = 1.
  - On handshake (ld_valid & ld_ready), latch ld_sel, ld_addr, ld_data and ld_last.
  - If the address is misaligned (ld_addr[1:0] != 0) or ld_addr > size-4 for the selected memory: set ld_err and drop the word. If ld_last was set, go to CLR; otherwise stay in IDLE.
  - Otherwise go to WRITE; busy = 1.
- WRITE:
  - ld_ready = 0.
  - Four consecutive cycles with mem_we = 1 and mem_sel = latched sel.
  - Byte k (k = 0..3) is written to address addr+k with data word[31-8k -: 8], i.e. MSB first at the lowest address.
  - After k = 3: go to CLR if the latched last flag is set, else IDLE.
  - Throughput is one word per 5 cycles (handshake cycle plus 4 write cycles).
- CLR: rf_clr = 1 for exactly one cycle; cpu_rst_n stays 0; next state is RUN.
- RUN:
  - cpu_rst_n = 1.
  - cycle_cnt increments each cycle and saturates at all-ones.
  - A repeat counter increments when pc_in equals its previous-cycle value and clears otherwise.
  - When the repeat count reaches HALT_REPEAT-1: set halted and go to DONE.
  - Otherwise, when cycle_cnt reaches RUN_CYCLES-1 in this cycle: set timeout and go to DONE.
  - If halt and timeout coincide in the same cycle, halt wins: halted = 1, timeout = 0.
- DONE:
  - cpu_rst_n = 0, done = 1, busy = 0, ld_ready = 0.
  - cycle_cnt, halted and timeout hold their values.
  - Only reset leaves this state.
- A load with ld_last on the very first word is legal: the run proceeds with whatever memory holds.
- ld_valid while ld_ready = 0 is ignored; the source must hold the word until the handshake.

Decomposition:
- Shared package mips_boot_pkg holds:
  - state enum (IDLE, WRITE, CLR, RUN, DONE)
  - MEM_IMEM = 1'b0, MEM_DMEM = 1'b1
  - BYTES_PER_WORD = 4
- One sub-module, mips_word_serialiser: takes a latched word, address and sel, and emits the 4 big-endian byte writes with a done pulse. The FSM and the run monitor remain in mips_boot_ctrl.

Test Plan:
1. Reset release, no stimulus -> ld_ready = 1, cpu_rst_n = 0, done = 0, all outputs at their reset values.
2. Load IMEM addr 0x0 word 0x8C010000 -> 4 cycles of mem_we writing (0,8C), (1,01), (2,00), (3,00), then ld_ready returns to 1.
3. Load DMEM addr 0x4 word 0x00000003 with ld_last -> bytes written at addresses 4..7 = 00,00,00,03; rf_clr high for 1 cycle; cpu_rst_n rises on the following cycle.
4. RUN with pc_in advancing by 4 every cycle, RUN_CYCLES = 20 -> timeout = 1, halted = 0, cycle_cnt = 20, done = 1, cpu_rst_n = 0.
5. RUN with pc_in stuck at 0x24 from cycle 5, HALT_REPEAT = 3 -> halted = 1 two cycles after the PC sticks, timeout = 0; also drive halt and timeout in the same cycle -> halted = 1, timeout = 0.
6. Load with ld_addr = 0x2 (misaligned) and, separately, ld_addr = IMEM_BYTES -> ld_err = 1 and no mem_we; assert rst_n = 0 mid-WRITE -> immediate return to IDLE with ld_err cleared.
